// File: rtl/off_mode_controller_delayed.sv
// Power-key classifier for non-OFF hood modes: long press requests OFF at once,
// short press arms a delayed-off run-on countdown that a further press cancels.
module off_mode_controller_delayed #(
  parameter int MODE_WIDTH      = 3,
  parameter int OFF_MODE        = 0,
  parameter int CNT_WIDTH       = 32,
  parameter int MIN_PRESS_COUNT = 2,
  parameter int HOLD_COUNT      = 3000,
  parameter int DELAY_COUNT     = 60000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  toggle_signal,
  input  logic [MODE_WIDTH-1:0] current_mode,
  output logic                  off_toggle,
  output logic                  countdown_active,
  output logic [CNT_WIDTH-1:0]  countdown_remaining,
  output logic                  short_press_pulse,
  output logic                  long_press_pulse,
  output logic                  cancel_pulse
);

  localparam logic [MODE_WIDTH-1:0] LP_OFF_MODE  = MODE_WIDTH'(OFF_MODE);
  localparam logic [CNT_WIDTH:0]    LP_HOLD      = (CNT_WIDTH+1)'(HOLD_COUNT);
  localparam logic [CNT_WIDTH:0]    LP_INC_ONE   = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0]  LP_MIN_PRESS = CNT_WIDTH'(MIN_PRESS_COUNT);
  localparam logic [CNT_WIDTH-1:0]  LP_DELAY     = CNT_WIDTH'(DELAY_COUNT);
  localparam logic [CNT_WIDTH-1:0]  LP_ONE       = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_COUNTDOWN,
    S_WAIT_RELEASE,
    S_FIRED
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_press_cnt;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic                 r_off;
  logic                 r_active;
  logic                 r_short;
  logic                 r_long;
  logic                 r_cancel;

  // One bit wider so the hold test cannot wrap before the long press fires.
  logic [CNT_WIDTH:0]   w_press_inc;
  logic                 w_mode_off;

  assign w_press_inc = {1'b0, r_press_cnt} + LP_INC_ONE;
  assign w_mode_off  = (current_mode == LP_OFF_MODE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_press_cnt <= '0;
      r_remaining <= '0;
      r_off       <= 1'b0;
      r_active    <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_cancel    <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_cancel <= 1'b0;
      if (w_mode_off) begin
        r_state     <= S_IDLE;
        r_press_cnt <= '0;
        r_remaining <= '0;
        r_off       <= 1'b0;
        r_active    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (toggle_signal) begin
              r_state     <= S_PRESSED;
              r_press_cnt <= LP_ONE;
            end
          end
          S_PRESSED: begin
            if (toggle_signal) begin
              if (w_press_inc >= LP_HOLD) begin
                r_state     <= S_FIRED;
                r_press_cnt <= '0;
                r_off       <= 1'b1;
                r_long      <= 1'b1;
              end else begin
                r_press_cnt <= w_press_inc[CNT_WIDTH-1:0];
              end
            end else begin
              r_press_cnt <= '0;
              if (r_press_cnt >= LP_MIN_PRESS) begin
                r_state     <= S_COUNTDOWN;
                r_remaining <= LP_DELAY;
                r_active    <= 1'b1;
                r_short     <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_COUNTDOWN: begin
            // A press during run-on cancels it and must be released before counting again.
            if (toggle_signal) begin
              r_state     <= S_WAIT_RELEASE;
              r_remaining <= '0;
              r_active    <= 1'b0;
              r_cancel    <= 1'b1;
            end else if (r_remaining == LP_ONE) begin
              r_state     <= S_FIRED;
              r_remaining <= '0;
              r_active    <= 1'b0;
              r_off       <= 1'b1;
            end else begin
              r_remaining <= r_remaining - LP_ONE;
            end
          end
          S_WAIT_RELEASE: begin
            if (!toggle_signal) begin
              r_state <= S_IDLE;
            end
          end
          S_FIRED: begin
            r_off <= 1'b1;
          end
          default: begin
            r_state     <= S_IDLE;
            r_press_cnt <= '0;
            r_remaining <= '0;
            r_off       <= 1'b0;
            r_active    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign off_toggle          = r_off;
  assign countdown_active    = r_active;
  assign countdown_remaining = r_remaining;
  assign short_press_pulse   = r_short;
  assign long_press_pulse    = r_long;
  assign cancel_pulse        = r_cancel;

endmodule

// File: doc/off_mode_controller_delayed.md
Name: off_mode_controller_delayed

Overview:
- Parametrised successor to the normal off-mode controller: classifies the debounced power-key input into glitch, short press and long press while the hood is in any non-OFF mode.
- A long press requests OFF immediately.
- A short press arms a delayed-off countdown, so the fan runs on to clear residual fumes; a further press cancels the countdown.
- Feeds the mode FSM alongside the other off-mode controllers, which consume the sticky off request.

Parameters:
MODE_WIDTH, 3, width of current_mode
OFF_MODE, 0, encoding of the OFF mode
CNT_WIDTH, 32, width of press counter and countdown counter
MIN_PRESS_COUNT, 2, minimum consecutive high samples for a valid short press (≥1)
HOLD_COUNT, 3000, consecutive high samples that make a long press (>MIN_PRESS_COUNT, <2^CNT_WIDTH)
DELAY_COUNT, 60000, delayed-off countdown length in cycles (≥1, <2^CNT_WIDTH)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
toggle_signal  in  1  debounced power-key level, 1 = pressed
current_mode  in  MODE_WIDTH  current hood mode from the mode FSM
off_toggle  out  1  sticky OFF request to the mode FSM
countdown_active  out  1  high while the delayed-off countdown runs
countdown_remaining  out  CNT_WIDTH  cycles left in the countdown, 0 when inactive
short_press_pulse  out  1  one-cycle pulse when a short press is accepted
long_press_pulse  out  1  one-cycle pulse when a long press fires
cancel_pulse  out  1  one-cycle pulse when a countdown is cancelled

Behaviour:
- Reset is asynchronous and active-low: state=IDLE, press_cnt=0; all outputs and counters 0. All other logic is registered on the clk rising edge.
- Highest priority: current_mode==OFF_MODE, sampled each cycle, forces next state IDLE, clears counters and all outputs, and overrides every transition below.
- Switching between non-OFF modes does not disturb state or counters.
- States: IDLE, PRESSED, COUNTDOWN, WAIT_RELEASE, FIRED.
- IDLE: toggle=1 → PRESSED, press_cnt=1.
- PRESSED, toggle=1:
  - If press_cnt+1 ≥ HOLD_COUNT → FIRED, with off_toggle=1 and long_press_pulse=1 on that same edge. off_toggle therefore rises at the edge sampling the HOLD_COUNT-th consecutive high.
  - Otherwise press_cnt increments.
- PRESSED, toggle=0:
  - If press_cnt ≥ MIN_PRESS_COUNT → COUNTDOWN, countdown_remaining=DELAY_COUNT, countdown_active=1, short_press_pulse=1.
  - Otherwise → IDLE (glitch rejected, no pulse).
  - press_cnt clears on either exit.
- COUNTDOWN, toggle=1 (priority over decrement): → WAIT_RELEASE, remaining=0, countdown_active=0, cancel_pulse=1.
- COUNTDOWN, toggle=0:
  - If remaining==1 → FIRED, off_toggle=1, remaining=0, countdown_active=0.
  - Otherwise remaining decrements by 1.
  - off_toggle therefore rises exactly DELAY_COUNT edges after the short-press acceptance edge.
- WAIT_RELEASE: toggle=0 → IDLE. The press that cancelled never counts as a new press, even if it is held ≥ HOLD_COUNT.
- FIRED: off_toggle stays 1; toggle_signal is ignored. Only current_mode==OFF_MODE or reset exits to IDLE.
- Pulses are registered, exactly one cycle wide, and never two in the same cycle.
- countdown_remaining is nonzero only while countdown_active=1.
- The press counter saturates by construction: the FIRED transition occurs before press_cnt can wrap. No counter wraps.
- Reset asserted mid-countdown or mid-press: immediate return to reset values; no pulse is emitted on deassertion.

Test Plan:
Use MIN_PRESS_COUNT=2, HOLD_COUNT=8, DELAY_COUNT=5, CNT_WIDTH=8, OFF_MODE=0, current_mode=2 unless stated.
1. Long press: toggle high 10 cycles → long_press_pulse and off_toggle rise at the 8th high sample edge. off_toggle stays 1 after release and drops only one edge after current_mode is set to 0.
2. Short press/delayed off: toggle high 3 cycles then low → short_press_pulse at release edge. countdown_remaining reads 5,4,3,2,1 over successive cycles, then off_toggle=1 with remaining=0 and countdown_active=0.
3. Glitch: toggle high 1 cycle → no pulse, stays IDLE, all outputs 0. With toggle high exactly 2 cycles, the press is accepted as short.
4. Cancel: short press, then toggle high when remaining=3, held 20 cycles → cancel_pulse once, remaining=0, no off_toggle and no long press. After release, a fresh 3-cycle press restarts the countdown at 5.
5. OFF override: current_mode driven to 0 during PRESSED (press_cnt=5) and, separately, during COUNTDOWN (remaining=2) → all outputs 0 next edge, no pulses. Mode change 2→1 mid-countdown → countdown continues uninterrupted.
6. Async reset: rstn low for half a cycle mid-countdown → outputs 0 immediately without waiting for clk. After rstn returns high, the block is IDLE and requires a new press.
